// File: rtl/mul8_rr_scheduler.sv
// Round-robin scheduler that shares one combinational 8x8 multiplier between NREQ requesters.
// Operand register (S1) and product register (S2) form a 2-stage stallable pipeline.
module mul8_rr_scheduler #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2,
   parameter int unsigned CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic [7:0]        mul_a,
   output logic [7:0]        mul_b,
   input  logic [15:0]       mul_o,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [15:0]       rsp_p,
   output logic              busy,
   output logic [CNTW-1:0]   op_count
);

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 16;

   logic            r_v1;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic [IDW-1:0]  r_id1;
   logic            r_v2;
   logic [PW-1:0]   r_p;
   logic [IDW-1:0]  r_id2;
   logic [IDW-1:0]  r_ptr;
   logic [CNTW-1:0] r_cnt;

   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_gid;
   logic            w_found;
   logic [DW-1:0]   w_a;
   logic [DW-1:0]   w_b;
   logic            w_en1;
   logic            w_en2;
   logic            w_accept;
   logic [IDW-1:0]  w_ptr_nxt;

   // Rotating priority: first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
   always_comb begin
      w_grant = '0;
      w_gid   = '0;
      w_found = 1'b0;
      w_a     = '0;
      w_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i] && (IDW'(i) >= r_ptr)) begin
            w_grant[i] = 1'b1;
            w_gid      = IDW'(i);
            w_found    = 1'b1;
            w_a        = req_a[DW*i +: DW];
            w_b        = req_b[DW*i +: DW];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i] && (IDW'(i) < r_ptr)) begin
            w_grant[i] = 1'b1;
            w_gid      = IDW'(i);
            w_found    = 1'b1;
            w_a        = req_a[DW*i +: DW];
            w_b        = req_b[DW*i +: DW];
         end
      end
   end

   assign w_en2     = ~r_v2 | rsp_ready;
   assign w_en1     = ~r_v1 | w_en2;
   assign w_accept  = w_found & w_en1;
   assign w_ptr_nxt = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_id1 <= '0;
         r_v2  <= 1'b0;
         r_p   <= '0;
         r_id2 <= '0;
         r_ptr <= '0;
         r_cnt <= '0;
      end else begin
         if (w_en2) begin
            r_v2  <= r_v1;
            r_p   <= mul_o;
            r_id2 <= r_id1;
         end
         // Operands only reload on an accept so the multiplier inputs stay quiet when idle.
         if (w_en1) begin
            r_v1 <= w_accept;
            if (w_accept) begin
               r_a   <= w_a;
               r_b   <= w_b;
               r_id1 <= w_gid;
            end
         end
         if (w_accept) begin
            r_ptr <= w_ptr_nxt;
         end
         if (r_v2 && rsp_ready) begin
            r_cnt <= r_cnt + CNTW'(1);
         end
      end
   end

   assign req_ready = w_grant & {NREQ{w_en1}};
   assign mul_a     = r_a;
   assign mul_b     = r_b;
   assign rsp_valid = r_v2;
   assign rsp_id    = r_id2;
   assign rsp_p     = r_p;
   assign busy      = r_v1 | r_v2;
   assign op_count  = r_cnt;

endmodule
